// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the video SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_ACCESS_CYCLES = 2;
  localparam int unsigned STARVE_W           = 8;
  localparam int unsigned ACC_CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } ArbState_t;

  typedef enum logic {
    GRANT_DISP,
    GRANT_REND
  } ArbGrant_t;

endpackage

// File: rtl/sram_access_sequencer.sv
// Drives one fixed-length SRAM access: strobes, address/data and read sampling.
module sram_access_sequencer
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACCESS_CYCLES = SRAM_ACCESS_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [ACC_CNT_W-1:0] LAST = ACC_CNT_W'(ACCESS_CYCLES - 1);

  logic                 active;
  logic [ACC_CNT_W-1:0] cnt;

  // Strobe/data registers: loaded at grant, write strobe released one cycle
  // early so the final access cycle holds data with we_n high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active     <= 1'b0;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else if (start) begin
      active     <= 1'b1;
      cnt        <= '0;
      sram_addr  <= addr;
      sram_dq_o  <= wdata;
      sram_dq_oe <= we;
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= we;
      sram_we_n  <= ~we;
    end else if (active) begin
      if (cnt == LAST) begin
        active     <= 1'b0;
        cnt        <= '0;
        sram_dq_oe <= 1'b0;
        sram_ce_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
        sram_we_n  <= 1'b1;
      end else begin
        cnt <= cnt + ACC_CNT_W'(1);
        if (cnt + ACC_CNT_W'(1) == LAST) begin
          sram_we_n <= 1'b1;
        end
      end
    end
  end

  // Completion marks the last access cycle; read data is sampled at its end.
  always_comb begin
    done  = active && (cnt == LAST);
    rdata = sram_dq_i;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Display/render arbiter for the single-port video SRAM.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACCESS_CYCLES = SRAM_ACCESS_CYCLES,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              rend_req,
  input  logic              rend_we,
  input  logic [ADDR_W-1:0] rend_addr,
  input  logic [DATA_W-1:0] rend_wdata,
  output logic              rend_ack,
  output logic [DATA_W-1:0] rend_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  ArbState_t           state;
  ArbState_t           stateNext;
  ArbGrant_t           grant;
  logic                grantWe;
  logic [STARVE_W-1:0] starve;
  logic                grantRend;
  logic                grantDisp;
  logic                start;
  logic                seqWe;
  logic [ADDR_W-1:0]   seqAddr;
  logic [DATA_W-1:0]   seqWdata;
  logic                seqDone;
  logic [DATA_W-1:0]   seqRdata;

  sram_access_sequencer #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (seqWe),
    .addr      (seqAddr),
    .wdata     (seqWdata),
    .done      (seqDone),
    .rdata     (seqRdata),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i (sram_dq_i),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  // Arbitration, request mux and next-state decode.
  always_comb begin
    grantRend = rend_req && (!disp_req || (starve == STARVE_MAX));
    grantDisp = disp_req && !grantRend;
    start     = 1'b0;
    stateNext = state;
    seqWe     = grantRend && rend_we;
    seqAddr   = grantRend ? rend_addr : disp_addr;
    seqWdata  = rend_wdata;
    case (state)
      IDLE: begin
        if (grantRend || grantDisp) begin
          start     = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        if (seqDone) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Grant record and starvation counter, both updated only when a grant is made.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant   <= GRANT_DISP;
      grantWe <= 1'b0;
      starve  <= '0;
    end else if (start) begin
      grant   <= grantRend ? GRANT_REND : GRANT_DISP;
      grantWe <= grantRend && rend_we;
      if (grantDisp && rend_req) begin
        if (starve != STARVE_MAX) begin
          starve <= starve + STARVE_W'(1);
        end
      end else begin
        starve <= '0;
      end
    end
  end

  // Ack steering and per-requester read data; writes leave rend_rdata alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_ack   <= 1'b0;
      rend_ack   <= 1'b0;
      disp_rdata <= '0;
      rend_rdata <= '0;
    end else begin
      disp_ack <= 1'b0;
      rend_ack <= 1'b0;
      if ((state == ACCESS) && seqDone) begin
        if (grant == GRANT_DISP) begin
          disp_ack   <= 1'b1;
          disp_rdata <= seqRdata;
        end else begin
          rend_ack <= 1'b1;
          if (!grantWe) begin
            rend_rdata <= seqRdata;
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, scoreboarded bench for sram_arbiter.
module tb_sram_arbiter;

  localparam int AC = 2;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int SL = 8;

  logic          clk;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [DW-1:0] disp_rdata;
  logic          rend_req;
  logic          rend_we;
  logic [AW-1:0] rend_addr;
  logic [DW-1:0] rend_wdata;
  logic          rend_ack;
  logic [DW-1:0] rend_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_i;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          busy;

  sram_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .ACCESS_CYCLES(AC),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_ack  (disp_ack),
    .disp_rdata(disp_rdata),
    .rend_req  (rend_req),
    .rend_we   (rend_we),
    .rend_addr (rend_addr),
    .rend_wdata(rend_wdata),
    .rend_ack  (rend_ack),
    .rend_rdata(rend_rdata),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i (sram_dq_i),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    bit            isDisp;
    logic [DW-1:0] rdata;
  } Exp_t;

  Exp_t          sb[$];
  Exp_t          e;
  logic [DW-1:0] lastRend;

  function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
    return (a == 20'h00100) ? 32'hDEADBEEF : {12'hC3A, a};
  endfunction

  // SRAM model: read data only valid once oe_n has been low for AC-1 cycles.
  int oeCnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) oeCnt <= 0;
    else      oeCnt <= sram_oe_n ? 0 : oeCnt + 1;
  end
  assign sram_dq_i = (!sram_oe_n && oeCnt == AC - 1) ? memModel(sram_addr) : 32'h0BAD0BAD;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the next expected grant.
  always @(negedge clk) begin
    if (rst && (disp_ack || rend_ack)) begin
      check("ackOverlap", 64'(disp_ack & rend_ack), 64'd0);
      if (sb.size() == 0) begin
        check("unexpectedAck", 64'({disp_ack, rend_ack}), 64'd0);
      end else begin
        e = sb.pop_front();
        check("ackWho", 64'(disp_ack), 64'(e.isDisp));
        check("ackRdata", 64'(e.isDisp ? disp_rdata : rend_rdata), 64'(e.rdata));
      end
    end
  end

  int            lat, ceLow, oeLow, weLow, oeHigh, ackCyc, n, firstAck;
  logic [AW-1:0] firstAddr;
  logic [DW-1:0] firstDq;

  function automatic void pushExp(input bit isDisp, input bit we, input logic [AW-1:0] a);
    Exp_t x;
    x.isDisp = isDisp;
    if (isDisp) begin
      x.rdata = memModel(a);
    end else begin
      if (!we) lastRend = memModel(a);
      x.rdata = lastRend;
    end
    sb.push_back(x);
  endfunction

  // One access from IDLE: drive, profile strobes per cycle until ack, release req.
  task automatic access(input bit isDisp, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    bit got;
    pushExp(isDisp, we, a);
    if (isDisp) begin
      disp_req = 1'b1; disp_addr = a;
    end else begin
      rend_req = 1'b1; rend_we = we; rend_addr = a; rend_wdata = wd;
    end
    lat = 0; ceLow = 0; oeLow = 0; weLow = 0; oeHigh = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!sram_ce_n) ceLow++;
      if (!sram_oe_n) oeLow++;
      if (!sram_we_n) weLow++;
      if (sram_dq_oe) oeHigh++;
      if (lat == 1) begin
        firstAddr = sram_addr;
        firstDq   = sram_dq_o;
      end
      if (isDisp ? disp_ack : rend_ack) begin
        got    = 1'b1;
        ackCyc = cycle;
      end
    end
    @(posedge clk);
    #1;
    disp_req = 1'b0;
    rend_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; lastRend = '0;
    disp_req = 1'b1; disp_addr = 20'h00100;
    rend_req = 1'b1; rend_we = 1'b0; rend_addr = 20'h00200; rend_wdata = '0;

    // Reset state with both requests pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstCe", 64'(sram_ce_n), 64'd1);
    check("rstOe", 64'(sram_oe_n), 64'd1);
    check("rstWe", 64'(sram_we_n), 64'd1);
    check("rstDqOe", 64'(sram_dq_oe), 64'd0);
    check("rstAddr", 64'(sram_addr), 64'd0);
    check("rstDq", 64'(sram_dq_o), 64'd0);
    check("rstAcks", 64'({disp_ack, rend_ack}), 64'd0);
    check("rstDispRdata", 64'(disp_rdata), 64'd0);
    check("rstRendRdata", 64'(rend_rdata), 64'd0);
    check("rstBusy", 64'(busy), 64'd0);

    // Release: display wins first, render follows once display drops.
    @(posedge clk); #1;
    pushExp(1'b1, 1'b0, 20'h00100);
    pushExp(1'b0, 1'b0, 20'h00200);
    rst = 1'b1;
    lat = 0; firstAck = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (disp_ack || rend_ack) begin
        firstAck = lat;
        break;
      end
    end
    check("rstFirstAckLat", 64'(firstAck), 64'(AC + 1));
    check("rstFirstIsDisp", 64'(disp_ack), 64'd1);
    @(posedge clk); #1;
    disp_req = 1'b0;
    lat = 0; firstAck = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rend_ack) begin
        firstAck = lat;
        break;
      end
    end
    check("rendAfterDispLat", 64'(firstAck), 64'(AC + 1));
    @(posedge clk); #1;
    rend_req = 1'b0;
    @(posedge clk); #1;

    // Display read.
    access(1'b1, 1'b0, 20'h00100, '0);
    check("dRdLat", 64'(lat), 64'(AC + 1));
    check("dRdCeLow", 64'(ceLow), 64'(AC));
    check("dRdOeLow", 64'(oeLow), 64'(AC));
    check("dRdWeLow", 64'(weLow), 64'd0);
    check("dRdAddr", 64'(firstAddr), 64'h00100);

    // Render write: rend_rdata must keep the previous read value.
    access(1'b0, 1'b1, 20'h12345, 32'hA5A5A5A5);
    check("rWrLat", 64'(lat), 64'(AC + 1));
    check("rWrCeLow", 64'(ceLow), 64'(AC));
    check("rWrWeLow", 64'(weLow), 64'(AC - 1));
    check("rWrDqOe", 64'(oeHigh), 64'(AC));
    check("rWrOeLow", 64'(oeLow), 64'd0);
    check("rWrAddr", 64'(firstAddr), 64'h12345);
    check("rWrData", 64'(firstDq), 64'hA5A5A5A5);

    // Render read at a new address.
    access(1'b0, 1'b0, 20'h00ABC, '0);
    check("rRdLat", 64'(lat), 64'(AC + 1));
    check("rRdAddr", 64'(firstAddr), 64'h00ABC);

    // Back-to-back display reads.
    access(1'b1, 1'b0, 20'h00100, '0);
    n = ackCyc;
    access(1'b1, 1'b0, 20'h00042, '0);
    check("b2bSpacing", 64'(ackCyc - n), 64'(AC + 2));

    // Contention: expected order SL display grants then one render, twice.
    for (int k = 0; k < 2 * (SL + 1); k++) begin
      pushExp((k % (SL + 1)) != SL, 1'b0, (k % (SL + 1)) != SL ? 20'h00100 : 20'h00300);
    end
    disp_req = 1'b1; disp_addr = 20'h00100;
    rend_req = 1'b1; rend_we = 1'b0; rend_addr = 20'h00300;
    n = 0;
    for (int i = 0; i < 300 && n < 2 * (SL + 1); i++) begin
      @(negedge clk);
      if (disp_ack || rend_ack) n++;
    end
    check("contentionAcks", 64'(n), 64'(2 * (SL + 1)));
    @(posedge clk); #1;
    disp_req = 1'b0;
    rend_req = 1'b0;
    @(negedge clk);
    check("sbDrained", 64'(sb.size()), 64'd0);

    // Reset during the first access cycle of a write.
    @(posedge clk); #1;
    rend_req = 1'b1; rend_we = 1'b1; rend_addr = 20'h55555; rend_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    check("mrWeActive", 64'(sram_we_n), 64'd0);
    rst = 1'b0;
    #1;
    check("mrWeN", 64'(sram_we_n), 64'd1);
    check("mrDqOe", 64'(sram_dq_oe), 64'd0);
    check("mrCeN", 64'(sram_ce_n), 64'd1);
    check("mrBusy", 64'(busy), 64'd0);
    rend_req = 1'b0; rend_we = 1'b0;
    lastRend = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (disp_ack || rend_ack) n++;
    end
    check("mrNoAck", 64'(n), 64'd0);
    check("mrRendRdata", 64'(rend_rdata), 64'd0);

    // Recovery after reset.
    @(posedge clk); #1;
    access(1'b1, 1'b0, 20'h00100, '0);
    check("postRstLat", 64'(lat), 64'(AC + 1));
    @(negedge clk);
    check("finalSbDrained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
